// File: rtl/uart_time_cmd_parser.sv
// rtl/uart_time_cmd_parser.sv - ASCII command and time-set frame decoder fed from the UART RX FIFO
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data, rx_valid     byte at RX FIFO head / FIFO not empty
//   rx_ready              pop strobe (byte consumed when rx_valid && rx_ready)
//   cmd_run/clear/mode    1-cycle control pulses
//   set_valid             1-cycle pulse, set_hour/min/sec freshly loaded
//   set_hour/min/sec      decoded time, held until next valid frame
//   cmd_err               1-cycle pulse on protocol/range/timeout error
//   busy                  set frame in progress
//   tx_data/valid/ready   echo of accepted bytes (only with CMD_ECHO_EN)
//
// Optional feature macro: CMD_ECHO_EN

module uart_time_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       cmd_run,
    output logic       cmd_clear,
    output logic       cmd_mode,
    output logic       set_valid,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       cmd_err,
`ifdef CMD_ECHO_EN
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
`endif
    output logic       busy
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, H10, H1, M10, M1, S10, S1, TERM} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [5:0][3:0] digits, digits_nxt;   // [0]=h10 ... [5]=s1
    logic            run_nxt, clear_nxt, mode_nxt, valid_nxt, err_nxt;
    logic [4:0]      hour_nxt;
    logic [5:0]      min_nxt, sec_nxt;
    logic            accept, is_digit, stall, is_eol;
    logic [2:0]      idx;
    logic [6:0]      h_val, m_val, s_val;

`ifdef CMD_ECHO_EN
    // A pending echo byte that TX cannot take freezes both intake and the timeout.
    assign stall    = tx_valid && !tx_ready;
    assign rx_ready = !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else if (accept) begin
            tx_data  <= rx_data;
            tx_valid <= 1'b1;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end
`else
    assign stall    = 1'b0;
    assign rx_ready = 1'b1;
`endif

    assign accept   = rx_valid && rx_ready;
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign busy     = (state != IDLE);
    // Digit slot for H10..S1; only used in those states.
    assign idx      = 3'(state) - 3'd1;

    // Digits are at most 9, so tens*10+units never exceeds 99 and fits 7 bits.
    assign h_val = {3'b000, digits[0]} * 7'd10 + {3'b000, digits[1]};
    assign m_val = {3'b000, digits[2]} * 7'd10 + {3'b000, digits[3]};
    assign s_val = {3'b000, digits[4]} * 7'd10 + {3'b000, digits[5]};

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        digits_nxt = digits;
        run_nxt    = 1'b0;
        clear_nxt  = 1'b0;
        mode_nxt   = 1'b0;
        valid_nxt  = 1'b0;
        err_nxt    = 1'b0;
        hour_nxt   = set_hour;
        min_nxt    = set_min;
        sec_nxt    = set_sec;

        if (accept) begin
            // An accept always wins over a coinciding timeout.
            cnt_nxt = '0;
            case (state)
                IDLE: begin
                    case (rx_data)
                        8'h52, 8'h72: run_nxt   = 1'b1;  // R r
                        8'h43, 8'h63: clear_nxt = 1'b1;  // C c
                        8'h4D, 8'h6D: mode_nxt  = 1'b1;  // M m
                        8'h54, 8'h74: state_nxt = H10;   // T t
                        8'h0D, 8'h0A, 8'h20: ;           // CR LF space
                        default:      err_nxt   = 1'b1;
                    endcase
                end
                H10, H1, M10, M1, S10, S1: begin
                    if (is_digit) begin
                        digits_nxt[idx] = rx_data[3:0];
                        state_nxt       = state_t'(3'(state) + 3'd1);
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin  // TERM
                    if (is_eol && (h_val < 7'd24) && (m_val < 7'd60) && (s_val < 7'd60)) begin
                        valid_nxt = 1'b1;
                        hour_nxt  = h_val[4:0];
                        min_nxt   = m_val[5:0];
                        sec_nxt   = s_val[5:0];
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
            endcase
        end else if (state == IDLE) begin
            cnt_nxt = '0;
        end else if (!stall) begin
            if (cnt == CNT_LAST) begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            digits    <= '0;
            cmd_run   <= 1'b0;
            cmd_clear <= 1'b0;
            cmd_mode  <= 1'b0;
            set_valid <= 1'b0;
            cmd_err   <= 1'b0;
            set_hour  <= '0;
            set_min   <= '0;
            set_sec   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            digits    <= digits_nxt;
            cmd_run   <= run_nxt;
            cmd_clear <= clear_nxt;
            cmd_mode  <= mode_nxt;
            set_valid <= valid_nxt;
            cmd_err   <= err_nxt;
            set_hour  <= hour_nxt;
            set_min   <= min_nxt;
            set_sec   <= sec_nxt;
        end
    end

endmodule
